mesi_snoop_responder: RTL and testbench
=======================================

// Module: mesi_snoop_responder
// PURPOSE
// - Responder side of the inter-core snoop handshake. It receives the peer core's coherence
//   request, looks up the local cache line state and updates it per MESI, then acknowledges.
// - If the local line is Modified, it flushes the line to the peer and to memory.
// - One instance sits in each core, on the peer-to-local request path.
// PARAMETERS
// ADDR_W  32  address width of snoop, lookup and writeback ports
// DATA_W  32  line (single word) data width
// PORTS
// clk            in   1       clock; all state updates on the rising edge
// reset          in   1       synchronous reset, active-high
// snp_valid      in   1       peer request valid; held high until snp_seen
// snp_op         in   2       00 BusRd, 01 BusRdX, 10 BusUpgr, 11 reserved
// snp_addr       in   ADDR_W  requested line address; stable while snp_valid
// snp_seen       out  1       one-cycle acknowledge of the request
// snp_shared     out  1       local copy was present (hit); valid with snp_seen
// snp_data_valid out  1       snp_data carries flushed M data; valid with snp_seen
// snp_data       out  DATA_W  flushed line data
// loc_busy       in   1       local core is updating the cache this cycle; defers acceptance
// snp_stall      out  1       high in every state except IDLE; local core must not touch the cache
// lk_req         out  1       one-cycle cache state/data lookup strobe
// lk_addr        out  ADDR_W  lookup/update address (latched snp_addr)
// lk_hit         in   1       lookup hit; valid the cycle after lk_req
// lk_state       in   2       MESI state I=00 S=01 E=10 M=11; valid the cycle after lk_req
// lk_data        in   DATA_W  line data; valid the cycle after lk_req
// st_we          out  1       one-cycle state write strobe to lk_addr
// st_state       out  2       new MESI state
// wb_wren        out  1       memory writeback request; held until wb_done
// wb_addr        out  ADDR_W  writeback address
// wb_data        out  DATA_W  writeback data
// wb_done        in   1       memory has accepted the writeback
// proto_err      out  1       sticky flag: illegal op/state combination seen
// BEHAVIOUR
// - Reset: FSM=IDLE; every output 0 (proto_err included).
//   - A reset mid-operation abandons the op with no st_we, no ack, and wb_wren dropped.
// - FSM states: IDLE, LOOKUP, WB, ACK.
// - IDLE:
//   - Accept when snp_valid && !loc_busy && !guard.
//   - On accept: latch op/addr, pulse lk_req, go to LOOKUP.
//   - While loc_busy is high, wait in IDLE.
// - LOOKUP: sample lk_*; decide the action from a miss, or from a hit per lk_state:
//   - miss or lk_state=I: no st_we, shared=0.
//   - BusRd, S or E: st_state=S, shared=1.
//   - BusRd, M: flush. st_state=S, shared=1.
//   - BusRdX, S or E: st_state=I, shared=1.
//   - BusRdX, M: flush. st_state=I, shared=1.
//   - BusUpgr, S: st_state=I, shared=1.
//   - BusUpgr, E or M: st_state=I, shared=1, set proto_err, no flush.
//   - Op 11: no action, set proto_err.
//   - On a flush: capture lk_data into snp_data and wb_data, go to WB.
//   - Otherwise: pulse st_we if needed, go to ACK.
// - WB: wb_wren=1 with wb_addr=lk_addr.
//   - If wb_done is seen in the same cycle: pulse st_we, go to ACK.
//   - Otherwise hold indefinitely.
// - ACK: snp_seen=1 for exactly one cycle with snp_shared and snp_data_valid; then go to IDLE.
//   - snp_data_valid=1 only if a flush occurred.
//   - snp_shared, snp_data_valid and snp_data hold their values until the next accept.
// - guard: set for the first cycle after ACK, blocking acceptance.
//   - The requester drops snp_valid in the cycle after snp_seen.
//   - The minimum gap from snp_seen to the next accept is 2 cycles.
// - Latency from accept edge to snp_seen:
//   - 2 cycles with no flush.
//   - 3 + (cycles waiting on wb_done) with a flush.
// - st_we is never asserted in the same cycle as lk_req; the cache sees at most one write per request.
// - Widths: addresses pass through unmodified; there is no arithmetic.
// TESTING
// 1. BusRd addr 0x40, lookup hit E
//    -> st_we with st_state=01 at cycle 1; snp_seen at cycle 2, shared=1, data_valid=0.
// 2. BusRdX addr 0x80, hit M with data 0xDEADBEEF, wb_done after 3 cycles
//    -> wb_wren held 3 cycles; st_state=00; snp_seen with data_valid=1, snp_data=0xDEADBEEF.
// 3. BusRd to a miss
//    -> no st_we, no wb_wren; snp_seen at cycle 2 with shared=0.
// 4. snp_valid with loc_busy high for 4 cycles
//    -> no lk_req until loc_busy falls; the request then completes normally.
// 5. BusUpgr on hit M; then op 11
//    -> st_state=00, proto_err=1 and stays 1; op 11 is acked with no st_we.
// 6. Reset asserted in the WB state
//    -> next cycle all outputs 0, FSM=IDLE, no st_we or snp_seen issued.

Source files
------------

// File: rtl/mesi_snoop_responder.sv
// MESI snoop responder: accepts a peer coherence request, looks up the local line,
// downgrades/invalidates it, flushes Modified data to memory, then acknowledges.
module mesi_snoop_responder #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              snp_valid_i,
    input  logic [1:0]        snp_op_i,
    input  logic [ADDR_W-1:0] snp_addr_i,
    output logic              snp_seen_o,
    output logic              snp_shared_o,
    output logic              snp_data_valid_o,
    output logic [DATA_W-1:0] snp_data_o,
    input  logic              loc_busy_i,
    output logic              snp_stall_o,
    output logic              lk_req_o,
    output logic [ADDR_W-1:0] lk_addr_o,
    input  logic              lk_hit_i,
    input  logic [1:0]        lk_state_i,
    input  logic [DATA_W-1:0] lk_data_i,
    output logic              st_we_o,
    output logic [1:0]        st_state_o,
    output logic              wb_wren_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    input  logic              wb_done_i,
    output logic              proto_err_o
);

    localparam logic [1:0] OpBusRd   = 2'b00;
    localparam logic [1:0] OpBusRdX  = 2'b01;
    localparam logic [1:0] OpBusUpgr = 2'b10;

    localparam logic [1:0] MesiI = 2'b00;
    localparam logic [1:0] MesiS = 2'b01;
    localparam logic [1:0] MesiM = 2'b11;

    typedef enum logic [1:0] {StIdle, StLookup, StWb, StAck} state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              lk_req_q;
    logic              guard_q;
    logic              shared_q;
    logic              dvalid_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        st_state_q;
    logic              proto_err_q;

    logic       accept;
    logic       decide;
    logic       dec_we;
    logic [1:0] dec_state;
    logic       dec_shared;
    logic       dec_flush;
    logic       dec_err;

    // Action table for the looked-up line; an Invalid hit is treated as a miss.
    always_comb begin
        dec_we     = 1'b0;
        dec_state  = MesiI;
        dec_shared = 1'b0;
        dec_flush  = 1'b0;
        dec_err    = 1'b0;
        if (op_q == 2'b11) begin
            dec_err = 1'b1;
        end else if (lk_hit_i && (lk_state_i != MesiI)) begin
            dec_we     = 1'b1;
            dec_shared = 1'b1;
            unique case (op_q)
                OpBusRd: begin
                    dec_state = MesiS;
                    dec_flush = (lk_state_i == MesiM);
                end
                OpBusRdX: begin
                    dec_flush = (lk_state_i == MesiM);
                end
                OpBusUpgr: begin
                    // Peer claims a shared copy while we hold E/M: protocol violation.
                    dec_err = (lk_state_i != MesiS);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        decide     = 1'b0;
        snp_seen_o = 1'b0;
        st_we_o    = 1'b0;
        st_state_o = MesiI;
        wb_wren_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (snp_valid_i && !loc_busy_i && !guard_q) begin
                    accept  = 1'b1;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                // First cycle issues lk_req; lookup results arrive on the second.
                if (!lk_req_q) begin
                    decide = 1'b1;
                    if (dec_flush) begin
                        state_d = StWb;
                    end else begin
                        st_we_o    = dec_we;
                        st_state_o = dec_we ? dec_state : MesiI;
                        state_d    = StAck;
                    end
                end
            end
            StWb: begin
                wb_wren_o = 1'b1;
                if (wb_done_i) begin
                    st_we_o    = 1'b1;
                    st_state_o = st_state_q;
                    state_d    = StAck;
                end
            end
            StAck: begin
                snp_seen_o = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            op_q        <= 2'b00;
            addr_q      <= '0;
            lk_req_q    <= 1'b0;
            guard_q     <= 1'b0;
            shared_q    <= 1'b0;
            dvalid_q    <= 1'b0;
            data_q      <= '0;
            st_state_q  <= MesiI;
            proto_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lk_req_q <= accept;
            guard_q  <= (state_q == StAck);
            if (accept) begin
                op_q   <= snp_op_i;
                addr_q <= snp_addr_i;
            end
            if (decide) begin
                shared_q   <= dec_shared;
                dvalid_q   <= dec_flush;
                st_state_q <= dec_state;
                if (dec_flush) begin
                    data_q <= lk_data_i;
                end
                if (dec_err) begin
                    proto_err_q <= 1'b1;
                end
            end
        end
    end

    assign snp_stall_o      = (state_q != StIdle);
    assign lk_req_o         = lk_req_q;
    assign lk_addr_o        = addr_q;
    assign wb_addr_o        = addr_q;
    assign wb_data_o        = data_q;
    assign snp_shared_o     = shared_q;
    assign snp_data_valid_o = dvalid_q;
    assign snp_data_o       = data_q;
    assign proto_err_o      = proto_err_q;

endmodule

// File: tb/tb_mesi_snoop_responder.sv
// Bench for mesi_snoop_responder: per-transaction timing model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mesi_snoop_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        snp_valid = 1'b0;
    logic [1:0]  snp_op = 2'b00;
    logic [31:0] snp_addr = 32'h0;
    logic        loc_busy = 1'b0;
    logic        lk_hit = 1'b0;
    logic [1:0]  lk_state = 2'b00;
    logic [31:0] lk_data = 32'h0;
    logic        wb_done;
    logic        snp_seen, snp_shared, snp_data_valid, snp_stall, lk_req, st_we, wb_wren;
    logic        proto_err;
    logic [31:0] snp_data, lk_addr, wb_addr, wb_data;
    logic [1:0]  st_state;

    int checks = 0;
    int errors = 0;

    mesi_snoop_responder #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk), .reset_i(reset),
        .snp_valid_i(snp_valid), .snp_op_i(snp_op), .snp_addr_i(snp_addr),
        .snp_seen_o(snp_seen), .snp_shared_o(snp_shared), .snp_data_valid_o(snp_data_valid),
        .snp_data_o(snp_data), .loc_busy_i(loc_busy), .snp_stall_o(snp_stall),
        .lk_req_o(lk_req), .lk_addr_o(lk_addr), .lk_hit_i(lk_hit), .lk_state_i(lk_state),
        .lk_data_i(lk_data), .st_we_o(st_we), .st_state_o(st_state), .wb_wren_o(wb_wren),
        .wb_addr_o(wb_addr), .wb_data_o(wb_data), .wb_done_i(wb_done), .proto_err_o(proto_err)
    );

    always #5 clk = ~clk;

    // Memory: accepts the writeback on the wb_lat-th cycle of wb_wren.
    int wb_lat = 1;
    int wb_run = 0;
    always @(posedge clk) wb_run <= wb_wren ? wb_run + 1 : 0;
    assign wb_done = wb_wren && (wb_run == wb_lat - 1);

    // Cumulative event counters sampled mid-cycle.
    int we_cnt = 0, wb_cyc = 0, lk_cnt = 0, seen_cnt = 0;
    logic [1:0] last_st = 2'b00;
    always @(negedge clk) begin
        if (st_we === 1'b1) begin
            we_cnt  = we_cnt + 1;
            last_st = st_state;
        end
        if (wb_wren === 1'b1) wb_cyc = wb_cyc + 1;
        if (lk_req === 1'b1) lk_cnt = lk_cnt + 1;
        if (snp_seen === 1'b1) seen_cnt = seen_cnt + 1;
    end

    // MESI response table: {we, new_state[1:0], shared, flush, err}.
    function automatic logic [5:0] rule(input logic [1:0] op, input logic hit,
                                        input logic [1:0] st);
        if (op == 2'b11) return 6'b000001;
        if (!hit || st == 2'b00) return 6'b000000;
        case (op)
            2'b00:   return {1'b1, 2'b01, 1'b1, (st == 2'b11), 1'b0};
            2'b01:   return {1'b1, 2'b00, 1'b1, (st == 2'b11), 1'b0};
            default: return {1'b1, 2'b00, 1'b1, 1'b0, (st != 2'b01)};
        endcase
    endfunction

    // Transaction model: age counts cycles since the accept edge.
    logic        m_active = 1'b0, m_guard = 1'b0, m_err = 1'b0, m_flush = 1'b0, m_done = 1'b0;
    logic        m_sh = 1'b0, m_dv = 1'b0;
    logic [1:0]  m_op = 2'b00, m_new = 2'b00;
    logic [31:0] m_addr = 32'h0, m_data = 32'h0;
    int          m_age = 0, m_done_age = 0;
    logic [5:0]  m_r;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0; m_guard = 1'b0; m_err = 1'b0; m_sh = 1'b0; m_dv = 1'b0;
            m_data = 32'h0; m_addr = 32'h0; m_done = 1'b0; m_flush = 1'b0; m_age = 0;
        end else if (!m_active) begin
            if (snp_valid && !loc_busy && !m_guard) begin
                m_active = 1'b1; m_age = 0; m_op = snp_op; m_addr = snp_addr;
                m_done = 1'b0; m_flush = 1'b0;
            end
            m_guard = 1'b0;
        end else begin
            if (m_age == 1) begin
                m_r = rule(m_op, lk_hit, lk_state);
                m_new = m_r[4:3]; m_sh = m_r[2]; m_flush = m_r[1]; m_dv = m_r[1];
                if (m_r[1]) m_data = lk_data;
                if (m_r[0]) m_err = 1'b1;
            end
            if ((!m_flush && m_age == 2) || (m_flush && m_done && m_age == m_done_age + 1)) begin
                m_active = 1'b0;
                m_guard  = 1'b1;
            end
            if (m_flush && m_age >= 2 && !m_done && wb_done) begin
                m_done = 1'b1;
                m_done_age = m_age;
            end
            m_age = m_age + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    logic       cmp_en = 1'b0;
    logic       e_ack, e_wb, e_lk, e_we;
    logic [1:0] e_st;
    logic [5:0] e_r;

    task automatic compare_cycle();
        e_lk  = m_active && m_age == 0;
        e_ack = m_active && ((!m_flush && m_age == 2) ||
                             (m_flush && m_done && m_age == m_done_age + 1));
        e_wb  = m_active && m_flush && m_age >= 2 && !m_done;
        e_we  = 1'b0;
        e_st  = 2'b00;
        if (m_active && m_age == 1) begin
            e_r  = rule(m_op, lk_hit, lk_state);
            e_we = e_r[5] && !e_r[1];
            if (e_we) e_st = e_r[4:3];
        end else if (e_wb && wb_done) begin
            e_we = 1'b1;
            e_st = m_new;
        end
        chk("snp_seen", {31'b0, snp_seen}, {31'b0, e_ack});
        chk("snp_shared", {31'b0, snp_shared}, {31'b0, m_sh});
        chk("snp_data_valid", {31'b0, snp_data_valid}, {31'b0, m_dv});
        chk("snp_data", snp_data, m_data);
        chk("snp_stall", {31'b0, snp_stall}, {31'b0, m_active});
        chk("lk_req", {31'b0, lk_req}, {31'b0, e_lk});
        chk("lk_addr", lk_addr, m_addr);
        chk("st_we", {31'b0, st_we}, {31'b0, e_we});
        chk("st_state", {30'b0, st_state}, {30'b0, e_st});
        chk("wb_wren", {31'b0, wb_wren}, {31'b0, e_wb});
        chk("wb_addr", wb_addr, m_addr);
        chk("wb_data", wb_data, m_data);
        chk("proto_err", {31'b0, proto_err}, {31'b0, m_err});
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input int busy,
                          output int lat, output int dwe, output int dwb, output int dlk,
                          output logic sh, output logic dv, output logic [31:0] dat);
        int we0, wb0, lk0, k, t_lk;
        logic got;
        @(posedge clk); #1;
        snp_valid = 1'b1; snp_op = op; snp_addr = addr; loc_busy = (busy > 0);
        we0 = we_cnt; wb0 = wb_cyc; lk0 = lk_cnt;
        for (int i = 0; i < busy; i++) begin
            @(posedge clk); #1;
        end
        dlk = lk_cnt - lk0;
        loc_busy = 1'b0;
        k = 0; t_lk = 0; got = 1'b0;
        sh = 1'b0; dv = 1'b0; dat = 32'h0;
        while (!got && k < 60) begin
            @(negedge clk);
            k = k + 1;
            if (lk_req) t_lk = k;
            if (snp_seen) begin
                got = 1'b1; sh = snp_shared; dv = snp_data_valid; dat = snp_data;
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        lat = k - t_lk;
        @(posedge clk); #1;
        snp_valid = 1'b0;
        dwe = we_cnt - we0;
        dwb = wb_cyc - wb0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    int          lat, dwe, dwb, dlk, we0, s0, n;
    logic        sh, dv;
    logic [31:0] dat;

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (cmp_en) compare_cycle();
            end
        join_none
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_stall", {31'b0, snp_stall}, 32'd0);
        chk("reset_perr", {31'b0, proto_err}, 32'd0);

        // 1: BusRd hit E
        lk_hit = 1'b1; lk_state = 2'b10; lk_data = 32'h1111_2222;
        do_req(2'b00, 32'h40, 0, lat, dwe, dwb, dlk, sh, dv, dat);
        chk("t1_lat", lat, 32'd2);
        chk("t1_we", dwe, 32'd1);
        chk("t1_st", {30'b0, last_st}, 32'd1);
        chk("t1_sh", {31'b0, sh}, 32'd1);
        chk("t1_dv", {31'b0, dv}, 32'd0);

        // 2: BusRdX hit M, writeback accepted on its third cycle
        lk_state = 2'b11; lk_data = 32'hDEAD_BEEF; wb_lat = 3;
        do_req(2'b01, 32'h80, 0, lat, dwe, dwb, dlk, sh, dv, dat);
        chk("t2_wb", dwb, 32'd3);
        chk("t2_lat", lat, 32'd5);
        chk("t2_st", {30'b0, last_st}, 32'd0);
        chk("t2_dv", {31'b0, dv}, 32'd1);
        chk("t2_data", dat, 32'hDEAD_BEEF);

        // 3: BusRd miss
        lk_hit = 1'b0;
        do_req(2'b00, 32'h100, 0, lat, dwe, dwb, dlk, sh, dv, dat);
        chk("t3_we", dwe, 32'd0);
        chk("t3_wb", dwb, 32'd0);
        chk("t3_lat", lat, 32'd2);
        chk("t3_sh", {31'b0, sh}, 32'd0);

        // 4: local core busy for 4 cycles, BusRd hit S
        lk_hit = 1'b1; lk_state = 2'b01;
        do_req(2'b00, 32'h140, 4, lat, dwe, dwb, dlk, sh, dv, dat);
        chk("t4_lk_busy", dlk, 32'd0);
        chk("t4_lat", lat, 32'd2);
        chk("t4_st", {30'b0, last_st}, 32'd1);
        chk("t4_sh", {31'b0, sh}, 32'd1);

        // 5: BusUpgr on M, then reserved op
        lk_state = 2'b11; lk_data = 32'h5555_AAAA;
        do_req(2'b10, 32'h180, 0, lat, dwe, dwb, dlk, sh, dv, dat);
        chk("t5_we", dwe, 32'd1);
        chk("t5_st", {30'b0, last_st}, 32'd0);
        chk("t5_wb", dwb, 32'd0);
        chk("t5_perr", {31'b0, proto_err}, 32'd1);
        lk_state = 2'b01;
        do_req(2'b11, 32'h1C0, 0, lat, dwe, dwb, dlk, sh, dv, dat);
        chk("t5b_we", dwe, 32'd0);
        chk("t5b_sh", {31'b0, sh}, 32'd0);
        chk("t5b_perr", {31'b0, proto_err}, 32'd1);

        // 6: reset while waiting on the writeback
        lk_state = 2'b11; lk_data = 32'h1234_5678; wb_lat = 1000;
        @(posedge clk); #1;
        snp_valid = 1'b1; snp_op = 2'b00; snp_addr = 32'hC0;
        n = 0;
        while (wb_wren !== 1'b1 && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("t6_reach_wb", {31'b0, wb_wren}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; snp_valid = 1'b0;
        we0 = we_cnt; s0 = seen_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_wren", {31'b0, wb_wren}, 32'd0);
        chk("t6_stall", {31'b0, snp_stall}, 32'd0);
        chk("t6_perr", {31'b0, proto_err}, 32'd0);
        chk("t6_wbaddr", wb_addr, 32'd0);
        chk("t6_data", snp_data, 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_no_we", we_cnt - we0, 32'd0);
        chk("t6_no_seen", seen_cnt - s0, 32'd0);

        // Recovery after reset: BusRdX hit E
        lk_state = 2'b10; wb_lat = 1;
        do_req(2'b01, 32'h200, 0, lat, dwe, dwb, dlk, sh, dv, dat);
        chk("t7_lat", lat, 32'd2);
        chk("t7_st", {30'b0, last_st}, 32'd0);
        chk("t7_sh", {31'b0, sh}, 32'd1);

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
